// File: rtl/cond_pkg.sv
// Shared definitions for the condition/flag-control unit: condition codes, NZCV bit
// positions, the delay-line entry type and parameter range checks.
package cond_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  // One delay-line stage: write mask (bit 1 = NZ, bit 0 = CV) plus the ALU flags.
  typedef struct packed {
    logic [1:0] mask;
    logic [3:0] flags;
  } flag_wr_t;

  function automatic bit flagw_delay_legal(input int unsigned d);
    return d <= 3;
  endfunction

  function automatic bit save_depth_legal(input int unsigned d);
    return (d >= 1) && (d <= 8);
  endfunction

endpackage

// File: rtl/cond_unit_if.sv
// Control-side bundle of the condition unit: FSM requests in, qualified enables and
// flag/stack status out.
interface cond_unit_if;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       InstrStart;
  logic       NextPC;
  logic       Branch;
  logic       RegW;
  logic       MemW;
  logic       FlagSave;
  logic       FlagRestore;
  logic       PCWrite;
  logic       RegWrite;
  logic       MemWrite;
  logic [3:0] Flags;
  logic       CondEx;
  logic       StackEmpty;
  logic       StackFull;
  logic       StackErr;

  modport master (
    output Cond, ALUFlags, FlagW, InstrStart, NextPC, Branch, RegW, MemW, FlagSave,
           FlagRestore,
    input  PCWrite, RegWrite, MemWrite, Flags, CondEx, StackEmpty, StackFull, StackErr
  );

  modport slave (
    input  Cond, ALUFlags, FlagW, InstrStart, NextPC, Branch, RegW, MemW, FlagSave,
           FlagRestore,
    output PCWrite, RegWrite, MemWrite, Flags, CondEx, StackEmpty, StackFull, StackErr
  );
endinterface

// File: rtl/condcheck.sv
// ARM condition-code evaluator against an NZCV flag set.
module condcheck
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  logic n, z, c, v, ge;

  assign n  = flags[FLAG_N];
  assign z  = flags[FLAG_Z];
  assign c  = flags[FLAG_C];
  assign v  = flags[FLAG_V];
  assign ge = (n == v);

  always_comb begin
    cond_ex = 1'b1;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = ge;
      COND_LT: cond_ex = ~ge;
      COND_GT: cond_ex = ~z & ge;
      COND_LE: cond_ex = z | ~ge;
      default: cond_ex = 1'b1;
    endcase
  end

endmodule

// File: rtl/flag_stack.sv
// LIFO of NZCV snapshots with push, pop, same-cycle swap and a sticky error flag.
module flag_stack #(
  parameter int unsigned Depth = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [3:0] din,
  output logic [3:0] top,
  output logic       pop_ok,
  output logic       empty,
  output logic       full,
  output logic       err
);

  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [3:0]      mem_q [Depth];
  logic [CntW-1:0] cnt_q, cnt_d, top_idx, wr_idx;
  logic            empty_q, full_q, err_q;
  logic            wr_en, err_set;

  assign top_idx = cnt_q - CntW'(1);

  always_comb begin
    top = '0;
    for (int i = 0; i < int'(Depth); i++) begin
      if (CntW'(i) == top_idx) top = mem_q[i];
    end
  end

  // Swap keeps the depth unchanged, so it takes precedence over overflow.
  always_comb begin
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    wr_idx  = cnt_q;
    pop_ok  = 1'b0;
    err_set = 1'b0;
    if (pop && empty_q) begin
      err_set = 1'b1;
      if (push) begin
        wr_en = 1'b1;
        cnt_d = cnt_q + CntW'(1);
      end
    end else if (push && pop) begin
      wr_en  = 1'b1;
      wr_idx = top_idx;
      pop_ok = 1'b1;
    end else if (pop) begin
      pop_ok = 1'b1;
      cnt_d  = cnt_q - CntW'(1);
    end else if (push) begin
      if (full_q) begin
        err_set = 1'b1;
      end else begin
        wr_en = 1'b1;
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
    end else begin
      cnt_q   <= cnt_d;
      empty_q <= (cnt_d == '0);
      full_q  <= (cnt_d == CntW'(Depth));
      err_q   <= err_q | err_set;
      for (int i = 0; i < int'(Depth); i++) begin
        if (wr_en && (CntW'(i) == wr_idx)) mem_q[i] <= din;
      end
    end
  end

  assign empty = empty_q;
  assign full  = full_q;
  assign err   = err_q;

endmodule

// File: rtl/cond_unit.sv
// Condition and flag-control unit: held per-instruction condition, qualified write
// enables, delayed NZ/CV flag update and a shadow flag stack.
module cond_unit
  import cond_pkg::*;
#(
  parameter int unsigned FLAGW_DELAY = 1,
  parameter int unsigned SAVE_DEPTH  = 4
) (
  input logic        clk,
  input logic        reset,
  cond_unit_if.slave bus
);

  if (!flagw_delay_legal(FLAGW_DELAY)) begin : g_bad_delay
    $error("cond_unit: FLAGW_DELAY must be 0..3");
  end
  if (!save_depth_legal(SAVE_DEPTH)) begin : g_bad_depth
    $error("cond_unit: SAVE_DEPTH must be 1..8");
  end

  logic [3:0] flags_q, stk_top;
  logic       cond_live, cond_held_q, cond_ex, pop_ok;
  flag_wr_t   wr_in, wr_out;

  condcheck u_condcheck (
    .cond    (bus.Cond),
    .flags   (flags_q),
    .cond_ex (cond_live)
  );

  assign cond_ex = bus.InstrStart ? cond_live : cond_held_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cond_held_q <= 1'b1;
    end else if (bus.InstrStart) begin
      cond_held_q <= cond_live;
    end
  end

  // Writes from failed instructions are squashed before entering the delay line.
  assign wr_in = '{mask: bus.FlagW & {2{cond_ex}}, flags: bus.ALUFlags};

  if (FLAGW_DELAY == 0) begin : g_no_dly
    assign wr_out = wr_in;
  end else begin : g_dly
    for (genvar g = 0; g < FLAGW_DELAY; g++) begin : g_stage
      flag_wr_t src;
      flag_wr_t stage_q;
      if (g == 0) begin : g_head
        assign src = wr_in;
      end else begin : g_tail
        assign src = g_stage[g-1].stage_q;
      end
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) stage_q <= '0;
        else        stage_q <= src;
      end
    end
    assign wr_out = g_stage[FLAGW_DELAY-1].stage_q;
  end

  flag_stack #(
    .Depth (SAVE_DEPTH)
  ) u_flag_stack (
    .clk    (clk),
    .reset  (reset),
    .push   (bus.FlagSave),
    .pop    (bus.FlagRestore),
    .din    (flags_q),
    .top    (stk_top),
    .pop_ok (pop_ok),
    .empty  (bus.StackEmpty),
    .full   (bus.StackFull),
    .err    (bus.StackErr)
  );

  // A restore request owns the flags this cycle; an underflowing one leaves them as-is.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q <= '0;
    end else if (bus.FlagRestore) begin
      if (pop_ok) flags_q <= stk_top;
    end else begin
      if (wr_out.mask[1]) flags_q[FLAG_N:FLAG_Z] <= wr_out.flags[FLAG_N:FLAG_Z];
      if (wr_out.mask[0]) flags_q[FLAG_C:FLAG_V] <= wr_out.flags[FLAG_C:FLAG_V];
    end
  end

  assign bus.Flags    = flags_q;
  assign bus.CondEx   = cond_ex;
  assign bus.PCWrite  = bus.NextPC | (bus.Branch & cond_ex);
  assign bus.RegWrite = bus.RegW & cond_ex;
  assign bus.MemWrite = bus.MemW & cond_ex;

endmodule
